// File: rtl/afu_mmio_csr_pkg.sv
// afu_csr_pkg: CSR word addresses, DFH builder, error bit indices and the
// minimal CCI-P MMIO request/response types consumed by the CSR endpoint.
package afu_csr_pkg;
    localparam logic [15:0] CSR_DFH       = 16'h000;
    localparam logic [15:0] CSR_AFU_ID_L  = 16'h002;
    localparam logic [15:0] CSR_AFU_ID_H  = 16'h004;
    localparam logic [15:0] CSR_NEXT_AFU  = 16'h006;
    localparam logic [15:0] CSR_RSVD      = 16'h008;
    localparam logic [15:0] CSR_SCRATCH   = 16'h00A;
    localparam logic [15:0] CSR_CYCLE_CNT = 16'h00C;
    localparam logic [15:0] CSR_CTRL      = 16'h00E;
    localparam logic [15:0] CSR_ERR       = 16'h010;

    localparam logic [3:0] DFH_TYPE_AFU = 4'h1;

    localparam int ERR_UNALIGNED = 0;
    localparam int ERR_BAD_LEN   = 1;
    localparam int ERR_COLLISION = 2;

    typedef enum logic [1:0] {
        LEN_4B  = 2'd0,
        LEN_8B  = 2'd1,
        LEN_64B = 2'd2
    } t_mmio_len;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    // AFU-type feature header, end-of-list set, no next feature.
    function automatic logic [63:0] dfh_build(input logic [3:0] rev);
        return {DFH_TYPE_AFU, 19'h0, 1'b1, 24'h0, rev, 12'h0};
    endfunction
endpackage

// File: rtl/afu_mmio_csr_if.sv
// afu_mmio_csr_if: registered CCI-P Rx MMIO requests in, c2 MMIO read responses out.
interface afu_mmio_csr_if;
    import afu_csr_pkg::*;
    t_if_ccip_Rx    cp2af_sRxPort;
    t_if_ccip_c2_Tx af2cp_sTxC2;
    modport master (output cp2af_sRxPort, input af2cp_sTxC2);
    modport slave (input cp2af_sRxPort, output af2cp_sTxC2);
endinterface

// File: rtl/afu_mmio_csr.sv
// afu_mmio_csr: CCI-P MMIO CSR endpoint with DFH, AFU ID, scratch, cycle counter,
// control and W1C error registers; reads answer with a fixed one-cycle latency.
module afu_mmio_csr
    import afu_csr_pkg::*;
#(
    parameter logic [63:0] AFU_ID_L      = 64'h0,
    parameter logic [63:0] AFU_ID_H      = 64'h0,
    parameter logic [3:0]  AFU_REV       = 4'h1,
    parameter logic [63:0] SCRATCH_RESET = 64'h0
) (
    input  logic          clk,
    input  logic          reset,
    afu_mmio_csr_if.slave ccip,
    output logic [63:0]   csr_scratch
);
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c2_Tx rsp_d, rsp_q;
    logic           rd, wr, odd, is_4b, is_8b, wen;
    logic [15:0]    waddr;
    logic [63:0]    rd_val, wdata, wmask, wbits;
    logic [63:0]    scratch_d, scratch_q, cnt_d, cnt_q;
    logic [2:0]     err_d, err_q, err_set, err_clr;

    always_comb begin
        c0 = ccip.cp2af_sRxPort.c0;
        rd = c0.mmioRdValid;
        wr = c0.mmioWrValid & ~rd;
        odd = c0.hdr.address[0];
        waddr = {c0.hdr.address[15:1], 1'b0};
        is_4b = c0.hdr.length == LEN_4B;
        is_8b = c0.hdr.length == LEN_8B;
        case (waddr)
            CSR_DFH:       rd_val = dfh_build(AFU_REV);
            CSR_AFU_ID_L:  rd_val = AFU_ID_L;
            CSR_AFU_ID_H:  rd_val = AFU_ID_H;
            CSR_SCRATCH:   rd_val = scratch_q;
            CSR_CYCLE_CNT: rd_val = cnt_q;
            CSR_ERR:       rd_val = {61'h0, err_q};
            CSR_NEXT_AFU, CSR_RSVD, CSR_CTRL: rd_val = '0;
            default:       rd_val = '0;
        endcase
        rsp_d = '0;
        rsp_d.mmioRdValid = rd;
        rsp_d.hdr.tid = c0.hdr.tid;
        rsp_d.data = is_8b ? (odd ? '0 : rd_val)
                   : is_4b ? {32'h0, odd ? rd_val[63:32] : rd_val[31:0]} : '0;
        // 4B writes carry their payload in data[31:0] whichever half they target.
        wen = wr & (is_4b | (is_8b & ~odd));
        wmask = is_8b ? '1 : odd ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF};
        wdata = is_8b ? c0.data : {2{c0.data[31:0]}};
        wbits = wdata & wmask;
        scratch_d = (wen && waddr == CSR_SCRATCH) ? (scratch_q & ~wmask) | wbits : scratch_q;
        cnt_d = (wen && waddr == CSR_CTRL && wbits[0]) ? '0 : cnt_q + 64'd1;
        err_clr = (wen && waddr == CSR_ERR) ? wbits[2:0] : '0;
        err_set = '0;
        err_set[ERR_UNALIGNED] = (rd | wr) & is_8b & odd;
        err_set[ERR_BAD_LEN] = (rd | wr) & ~is_4b & ~is_8b;
        err_set[ERR_COLLISION] = rd & c0.mmioWrValid;
        err_d = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scratch_q <= SCRATCH_RESET;
            cnt_q <= '0;
            err_q <= '0;
            rsp_q <= '0;
        end else begin
            scratch_q <= scratch_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            rsp_q <= rsp_d;
        end
    end

    // Gating with reset kills a response already registered when reset arrives.
    assign ccip.af2cp_sTxC2 = reset ? '0 : rsp_q;
    assign csr_scratch = scratch_q;
endmodule

// File: tb/tb_afu_mmio_csr.sv
// tb_afu_mmio_csr: directed plus random MMIO traffic checked against a
// register-map reference model of the CSR endpoint.
module tb_afu_mmio_csr;
    import afu_csr_pkg::*;

    localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] SR   = 64'h5A5A_0000_0000_A5A5;
    localparam logic [63:0] DFH_EXP = 64'h1000_0100_0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] csr_scratch;
    afu_mmio_csr_if bus ();

    afu_mmio_csr #(.AFU_ID_L(ID_L), .AFU_ID_H(ID_H), .AFU_REV(4'h1), .SCRATCH_RESET(SR)) dut (
        .clk(clk), .reset(reset), .ccip(bus.slave), .csr_scratch(csr_scratch));

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass = 0;
    logic [63:0] m_scratch, m_cnt, pend_data, obs_data, c0_val;
    logic [2:0]  m_err;
    logic [8:0]  pend_tid;
    bit          pend_vld = 0;
    bit          known = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model_rd(input logic [15:0] a, input logic [1:0] l);
        logic [63:0] v;
        case (int'(a) / 2)
            0: v = DFH_EXP;
            1: v = ID_L;
            2: v = ID_H;
            5: v = m_scratch;
            6: v = m_cnt;
            8: v = 64'(m_err);
            default: v = 0;
        endcase
        if (l == 1) return (a % 2 == 1) ? 64'h0 : v;
        if (l == 0) return (a % 2 == 1) ? v >> 32 : v & 64'hFFFF_FFFF;
        return 64'h0;
    endfunction

    task automatic step(input bit r, input bit rd, input bit wr, input logic [15:0] a,
                        input logic [1:0] l, input logic [8:0] t, input logic [63:0] d);
        t_if_ccip_Rx rx;
        bit wr_ok, clr;
        int base;
        @(negedge clk);
        reset = r;
        rx = '0;
        rx.c0.mmioRdValid = rd;
        rx.c0.mmioWrValid = wr;
        rx.c0.hdr.address = a;
        rx.c0.hdr.length = l;
        rx.c0.hdr.tid = t;
        rx.c0.data = d;
        bus.cp2af_sRxPort = rx;
        #1;
        chk("rd_valid", 64'(bus.af2cp_sTxC2.mmioRdValid), 64'(pend_vld && !r));
        if (pend_vld && !r) begin
            chk("rd_tid", 64'(bus.af2cp_sTxC2.hdr.tid), 64'(pend_tid));
            chk("rd_data", bus.af2cp_sTxC2.data, pend_data);
        end
        if (r) chk("rst_data", bus.af2cp_sTxC2.data, 64'h0);
        if (known) chk("scratch", csr_scratch, m_scratch);
        obs_data = bus.af2cp_sTxC2.data;
        if (r) begin
            pend_vld = 0;
            m_scratch = SR;
            m_cnt = 0;
            m_err = 0;
            known = 1;
        end else begin
            pend_vld = rd;
            pend_tid = t;
            pend_data = rd ? model_rd(a, l) : 64'h0;
            wr_ok = wr && !rd;
            clr = 0;
            base = int'(a) / 2 * 8;
            if (wr_ok && l == 1 && a % 2 == 0) begin
                if (base == 'h28) m_scratch = d;
                if (base == 'h38 && d[0]) clr = 1;
                if (base == 'h40) m_err = m_err & ~d[2:0];
            end
            if (wr_ok && l == 0) begin
                if (base == 'h28 && a % 2 == 1) m_scratch = {d[31:0], m_scratch[31:0]};
                if (base == 'h28 && a % 2 == 0) m_scratch = {m_scratch[63:32], d[31:0]};
                if (base == 'h38 && a % 2 == 0 && d[0]) clr = 1;
                if (base == 'h40 && a % 2 == 0) m_err = m_err & ~d[2:0];
            end
            if ((rd || wr_ok) && l == 1 && a % 2 == 1) m_err = m_err | 3'd1;
            if ((rd || wr_ok) && l >= 2) m_err = m_err | 3'd2;
            if (rd && wr) m_err = m_err | 3'd4;
            m_cnt = clr ? 64'h0 : m_cnt + 1;
        end
    endtask

    task automatic rd8(input logic [15:0] a);
        step(0, 1, 0, a, 2'd1, 9'h1A5, 64'h0);
    endtask

    task automatic idle();
        step(0, 0, 0, 16'h0, 2'd0, 9'h0, 64'h0);
    endtask

    initial begin
        bus.cp2af_sRxPort = '0;
        step(1, 0, 0, 16'h0, 2'd0, 9'h0, 64'h0);
        step(1, 1, 0, 16'h0, 2'd1, 9'h3, 64'h0);
        rd8(16'h000);
        rd8(16'h002);
        chk("dfh", obs_data, DFH_EXP);
        rd8(16'h004);
        chk("afu_id_l", obs_data, ID_L);
        idle();
        chk("afu_id_h", obs_data, ID_H);
        step(0, 0, 1, 16'h00A, 2'd1, 9'h0, 64'hDEAD_BEEF_CAFE_F00D);
        step(0, 0, 1, 16'h00B, 2'd0, 9'h0, 64'h0000_0000_1234_5678);
        rd8(16'h00A);
        step(0, 1, 0, 16'h00B, 2'd0, 9'h2, 64'h0);
        chk("scratch_merge", obs_data, 64'h1234_5678_CAFE_F00D);
        idle();
        chk("scratch_hi4b", obs_data, 64'h0000_0000_1234_5678);
        rd8(16'h00C);
        idle();
        c0_val = obs_data;
        for (int i = 0; i < 8; i++) idle();
        rd8(16'h00C);
        idle();
        chk("cnt_delta", obs_data - c0_val, 64'd10);
        step(0, 0, 1, 16'h00E, 2'd1, 9'h0, 64'h1);
        idle();
        rd8(16'h00C);
        idle();
        chk("cnt_clear", obs_data, 64'd1);
        rd8(16'h003);
        rd8(16'h010);
        chk("odd8_data", obs_data, 64'h0);
        idle();
        chk("err_unaligned", obs_data, 64'h1);
        step(0, 1, 0, 16'h000, 2'd2, 9'h7, 64'h0);
        rd8(16'h010);
        chk("len2_data", obs_data, 64'h0);
        idle();
        chk("err_badlen", obs_data, 64'h3);
        step(0, 0, 1, 16'h010, 2'd1, 9'h0, 64'h1);
        rd8(16'h010);
        idle();
        chk("err_w1c", obs_data, 64'h2);
        step(0, 1, 1, 16'h00A, 2'd1, 9'h11, 64'h1111_2222_3333_4444);
        rd8(16'h010);
        chk("collide_old", obs_data, 64'h1234_5678_CAFE_F00D);
        rd8(16'h100);
        chk("err_collide", obs_data, 64'h6);
        step(0, 1, 0, 16'h101, 2'd0, 9'h4, 64'h0);
        chk("unmapped8", obs_data, 64'h0);
        idle();
        chk("unmapped4", obs_data, 64'h0);
        rd8(16'h00A);
        step(1, 0, 0, 16'h0, 2'd0, 9'h0, 64'h0);
        idle();
        chk("scratch_rst", csr_scratch, SR);
        for (int i = 0; i < 600; i++) begin
            int op;
            logic [15:0] a;
            logic [1:0] l;
            op = int'($urandom_range(0, 15));
            a = ($urandom_range(0, 7) == 0) ? 16'(16'h100 + $urandom_range(0, 3))
                                            : 16'($urandom_range(0, 19));
            l = ($urandom_range(0, 7) < 6) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            step($urandom_range(0, 79) == 0, op < 6 || op == 12, op >= 6 && op <= 12, a, l,
                 9'($urandom), {$urandom, $urandom});
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
